// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - round-robin time-sharing controller for one combinational ALU
// Two valid/ready requesters in, registered ALU operands out, tagged response with backpressure.
module alu_share_ctrl #(
    parameter int DW = 32,
    parameter int FW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [DW-1:0] req0_in1,
    input  logic [DW-1:0] req0_in2,
    input  logic [FW-1:0] req0_func,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [DW-1:0] req1_in1,
    input  logic [DW-1:0] req1_in2,
    input  logic [FW-1:0] req1_func,
    output logic [DW-1:0] alu_in1,
    output logic [DW-1:0] alu_in2,
    output logic [FW-1:0] alu_func,
    input  logic [DW-1:0] alu_out,
    input  logic          alu_z,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_z
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          last_id_q, last_id_d;
    logic [DW-1:0] alu_in1_q, alu_in1_d;
    logic [DW-1:0] alu_in2_q, alu_in2_d;
    logic [FW-1:0] alu_func_q, alu_func_d;
    logic          rsp_id_q, rsp_id_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic          rsp_z_q, rsp_z_d;

    logic grant_id;
    logic accept;

    // On a tie the requester not served last wins; a lone valid always wins.
    assign grant_id = (req0_valid && req1_valid) ? ~last_id_q : req1_valid;
    assign accept   = (state_q == IDLE) && (req0_valid || req1_valid) && !rst;

    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept && grant_id;

    always_comb begin
        state_d    = state_q;
        last_id_d  = last_id_q;
        alu_in1_d  = alu_in1_q;
        alu_in2_d  = alu_in2_q;
        alu_func_d = alu_func_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        rsp_z_d    = rsp_z_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = EXEC;
                    last_id_d  = grant_id;
                    rsp_id_d   = grant_id;
                    alu_in1_d  = grant_id ? req1_in1  : req0_in1;
                    alu_in2_d  = grant_id ? req1_in2  : req0_in2;
                    alu_func_d = grant_id ? req1_func : req0_func;
                end
            end
            EXEC: begin
                state_d    = RESP;
                rsp_data_d = alu_out;
                rsp_z_d    = alu_z;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_id_q  <= 1'b1;
            alu_in1_q  <= '0;
            alu_in2_q  <= '0;
            alu_func_q <= '0;
            rsp_id_q   <= 1'b0;
            rsp_data_q <= '0;
            rsp_z_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_id_q  <= last_id_d;
            alu_in1_q  <= alu_in1_d;
            alu_in2_q  <= alu_in2_d;
            alu_func_q <= alu_func_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
            rsp_z_q    <= rsp_z_d;
        end
    end

    assign alu_in1   = alu_in1_q;
    assign alu_in2   = alu_in2_q;
    assign alu_func  = alu_func_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_z     = rsp_z_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb/tb_alu_share_ctrl.sv - directed bench for alu_share_ctrl with a behavioural ALU attached
module tb_alu_share_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready;
    logic [31:0] req0_in1, req0_in2;
    logic [2:0]  req0_func;
    logic        req1_valid, req1_ready;
    logic [31:0] req1_in1, req1_in2;
    logic [2:0]  req1_func;
    logic [31:0] alu_in1, alu_in2, alu_out;
    logic [2:0]  alu_func;
    logic        alu_z;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_z;
    logic [31:0] rsp_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_share_ctrl #(.DW(32), .FW(3)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_func(req0_func),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_func(req1_func),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_func(alu_func),
        .alu_out(alu_out), .alu_z(alu_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_z(rsp_z)
    );

    // MIPS-style ALU driven by the controller's registered operands
    always_comb begin
        alu_out = '0;
        case (alu_func)
            3'b010: alu_out = alu_in1 + alu_in2;
            3'b101: alu_out = alu_in1 - alu_in2;
            3'b000: alu_out = alu_in1 << alu_in2[4:0];
            3'b011: alu_out = alu_in1 >> alu_in2[4:0];
            3'b100: alu_out = $unsigned($signed(alu_in1) >>> alu_in2[4:0]);
            3'b001: alu_out = alu_in1 | alu_in2;
            3'b110: alu_out = alu_in1 & alu_in2;
            default: alu_out = alu_in1 ^ alu_in2;
        endcase
    end
    assign alu_z = (alu_out == 32'd0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b0; req0_in1 = '0; req0_in2 = '0; req0_func = '0;
        req1_valid = 1'b0; req1_in1 = '0; req1_in2 = '0; req1_func = '0;
        tick(); tick();

        // reset state, ready held low while rst is asserted
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_alu_in1", alu_in1, 0);
        chk("rst_alu_in2", alu_in2, 0);
        chk("rst_alu_func", alu_func, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_z", rsp_z, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;
        tick();

        // single ADD from req0
        req0_valid = 1'b1; req0_in1 = 32'd5; req0_in2 = 32'd7; req0_func = 3'b010;
        #1;
        chk("add_req0_ready", req0_ready, 1);
        chk("add_req1_ready", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        chk("add_exec_in1", alu_in1, 5);
        chk("add_exec_in2", alu_in2, 7);
        chk("add_exec_func", alu_func, 3'b010);
        chk("add_exec_rsp_valid", rsp_valid, 0);
        tick();
        chk("add_rsp_valid", rsp_valid, 1);
        chk("add_rsp_data", rsp_data, 12);
        chk("add_rsp_z", rsp_z, 0);
        chk("add_rsp_id", rsp_id, 0);
        tick();
        chk("add_idle_rsp_valid", rsp_valid, 0);

        // zero flag from req1 SUB
        req1_valid = 1'b1; req1_in1 = 32'd9; req1_in2 = 32'd9; req1_func = 3'b101;
        #1;
        chk("sub_req1_ready", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        tick();
        chk("sub_rsp_valid", rsp_valid, 1);
        chk("sub_rsp_data", rsp_data, 0);
        chk("sub_rsp_z", rsp_z, 1);
        chk("sub_rsp_id", rsp_id, 1);
        tick();

        // contention from reset, then alternation
        rst = 1'b1; tick(); rst = 1'b0;
        req0_valid = 1'b1; req0_in1 = 32'h0000_00F0; req0_in2 = 32'h0000_000F; req0_func = 3'b001;
        req1_valid = 1'b1; req1_in1 = 32'h8000_0000; req1_in2 = 32'd4;          req1_func = 3'b011;
        #1;
        chk("tie1_req0_ready", req0_ready, 1);
        chk("tie1_req1_ready", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        chk("tie1_exec_req1_ready", req1_ready, 0);
        tick();
        chk("tie1_rsp_data", rsp_data, 32'h0000_00FF);
        chk("tie1_rsp_id", rsp_id, 0);
        tick();
        chk("tie1_loser_ready", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        tick();
        chk("tie1b_rsp_data", rsp_data, 32'h0800_0000);
        chk("tie1b_rsp_id", rsp_id, 1);
        tick();
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("tie2_req0_ready", req0_ready, 1);
        chk("tie2_req1_ready", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        tick();
        chk("tie2_rsp_id", rsp_id, 0);
        tick();
        chk("tie2_loser_ready", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        tick();
        chk("tie2b_rsp_id", rsp_id, 1);
        chk("tie2b_rsp_data", rsp_data, 32'h0800_0000);
        tick();

        // backpressure with req0 waiting behind the held response
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_in1 = 32'd1; req0_in2 = 32'd2; req0_func = 3'b010;
        tick();
        req0_in1 = 32'd10; req0_in2 = 32'd20;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_data", rsp_data, 3);
            chk("bp_rsp_id", rsp_id, 0);
            chk("bp_req0_ready", req0_ready, 0);
            chk("bp_alu_in1", alu_in1, 1);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_hs_req0_ready", req0_ready, 0);
        tick();
        chk("bp_after_rsp_valid", rsp_valid, 0);
        chk("bp_after_req0_ready", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        chk("bp_next_alu_in1", alu_in1, 10);
        tick();
        chk("bp_next_rsp_data", rsp_data, 30);
        tick();

        // reset during EXEC discards the op
        req1_valid = 1'b1; req1_in1 = 32'h0000_00FF; req1_in2 = 32'h0000_000F; req1_func = 3'b111;
        tick();
        req1_valid = 1'b0;
        chk("rx_exec_alu_func", alu_func, 3'b111);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rx_rsp_valid", rsp_valid, 0);
        chk("rx_alu_in1", alu_in1, 0);
        chk("rx_alu_func", alu_func, 0);
        chk("rx_rsp_id", rsp_id, 0);
        chk("rx_rsp_data", rsp_data, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rx_no_rsp", rsp_valid, 0);
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_in1 = 32'd3; req0_in2 = 32'd1; req0_func = 3'b000;
        #1;
        chk("rx_tie_req0_ready", req0_ready, 1);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        chk("rx_sll_rsp_data", rsp_data, 6);
        chk("rx_sll_rsp_id", rsp_id, 0);
        tick();

        // req1 valid pulse during RESP must not produce an op
        req0_valid = 1'b1; req0_in1 = 32'hFFFF_FF00; req0_in2 = 32'd4; req0_func = 3'b100;
        tick();
        req0_valid = 1'b0;
        tick();
        rsp_ready = 1'b0;
        req1_valid = 1'b1; req1_in1 = 32'd1; req1_in2 = 32'd1; req1_func = 3'b010;
        #1;
        chk("wd_req1_ready", req1_ready, 0);
        chk("wd_rsp_data", rsp_data, 32'hFFFF_FFF0);
        chk("wd_rsp_id", rsp_id, 0);
        tick();
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("wd_no_rsp", rsp_valid, 0);
            chk("wd_no_ready1", req1_ready, 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequential controller that time-shares the single-cycle combinational ALU between two requesters, for example the execute stage and the branch/address unit of the simplified MIPS core. Each requester issues an operation over a valid/ready handshake. The controller arbitrates round-robin, registers and drives the operands and function code into the ALU, then captures the result and zero flag. It returns them on a response channel with backpressure, tagged with the requester id.

## Interface
- DW, 32, operand/result width
- FW, 3, ALU function-code width
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  controller accepts requester 0 this cycle
- req0_in1, req0_in2  in  DW  requester 0 operands
- req0_func  in  FW  requester 0 function code
- req1_valid / req1_ready / req1_in1 / req1_in2 / req1_func: same as requester 0, for requester 1
- alu_in1, alu_in2  out  DW  registered operands to ALU
- alu_func  out  FW  registered function code to ALU
- alu_out  in  DW  ALU result
- alu_z  in  1  ALU zero flag
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_id  out  1  requester that issued the op
- rsp_data  out  DW  captured result
- rsp_z  out  1  captured zero flag

## Operation
- Function codes are passed through unmodified: ADD 3'b010, SUB 3'b101, SLL 3'b000, SRL 3'b011, SRA 3'b100, OR 3'b001, AND 3'b110, XOR 3'b111. All 8 codes are legal. The controller performs no arithmetic.
- FSM states:
  - IDLE: arbitrate. Exactly one reqN_ready is high, combinationally, when at least one valid is high.
  - EXEC: the ALU evaluates the registered operands.
  - RESP: the response is held.
- IDLE with valid present: on the accepting edge, latch the granted payload into alu_in1/alu_in2/alu_func, record the id, and go to EXEC. With no valid, stay in IDLE.
- Arbitration: a last_id register holds the last requester served.
  - One valid: grant it.
  - Both valid: grant !last_id.
  - last_id updates on accept.
- EXEC: at the end of the cycle, capture alu_out into rsp_data and alu_z into rsp_z, then go to RESP. This is unconditional, exactly one cycle.
- RESP: rsp_valid=1. When rsp_valid&rsp_ready, go to IDLE. Otherwise hold every rsp_* and alu_* output stable.
- reqN_ready is 0 in EXEC and RESP. There is no acceptance while an op is in flight.
- Requesters hold their payload while valid&&!ready. If valid drops before grant, no op is issued.
- alu_in1/alu_in2/alu_func stay stable from EXEC through RESP. They change only on a new accept or on reset.

## Timing
- Reset values: state IDLE, last_id=1 (requester 0 wins the first tie), alu_in1=alu_in2=0, alu_func=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_z=0. reqN_ready is 0 during the rst cycle.
- Latency: accept edge T, EXEC during cycle T+1, rsp_valid=1 in cycle T+2.
- Issue interval: minimum 3 cycles per op with rsp_ready tied high (accept, EXEC, RESP+handshake). IDLE is re-entered on the cycle after the handshake.
- Backpressure: RESP is held indefinitely while rsp_ready=0, with no data change.
- Simultaneous valids: arbitration follows the round-robin rule. The losing requester keeps valid high and is served next.
- Reset mid-operation (EXEC or RESP): the in-flight op is discarded. The cycle after rst has rsp_valid=0, state IDLE, and last_id=1. No response is ever produced for the aborted op.
- rsp_valid does not depend combinationally on rsp_ready. reqN_ready depends only on state, valids and last_id.

## Test plan
- Single ADD: req0 with in1=5, in2=7, func=3'b010. Required: req0_ready high that cycle; alu_in1=5, alu_in2=7 next cycle; rsp_valid 2 cycles after accept with rsp_data=12, rsp_z=0, rsp_id=0.
- Zero flag: req1 SUB with in1=9, in2=9, func=3'b101. Required: rsp_data=0, rsp_z=1, rsp_id=1.
- Contention: both valid from reset (req0 OR 0xF0|0x0F, req1 SRL 0x80000000>>4), rsp_ready high. Required: req0 served first with rsp_data=0xFF, then req1 with 0x08000000. Repeat both valid: req0 served next (alternation).
- Backpressure: hold rsp_ready=0 for 4 cycles during RESP while req0_valid is high. Required: rsp_* stable, req0_ready=0 throughout; accept occurs the cycle after the handshake.
- Reset in EXEC: assert rst for 1 cycle during EXEC. Required: rsp_valid never rises for that op; all outputs at reset values; next tie grants req0.
- Valid withdrawal: req1_valid pulses high then low while in RESP. Required: no response with rsp_id=1 and no extra accept.
